fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and the decoder.
- Captures fetched instruction packets: instr, pc, predicted next pc, predicted direction.
- Presents them in order to decode through a valid/ready handshake.
- Absorbs fetch/decode rate mismatch; is cleared whole on a front-end redirect (decode first-check mispredict or backend flush).

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer index width. Pointers carry one extra wrap bit.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all entries this cycle (redirect)
- in_valid  input  1  fetch presents a packet
- in_ready  output  1  queue can accept a packet
- in_instr  input  32  fetched instruction
- in_pc  input  32  pc of instruction
- in_pre_pc  input  32  predicted next pc
- in_pre_direction  input  1  predicted taken
- out_valid  output  1  head packet available to decode
- out_ready  input  1  decode consumes head
- out_instr  output  32  head instruction
- out_pc  output  32  head pc
- out_pre_pc  output  32  head predicted next pc
- out_pre_direction  output  1  head predicted taken
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset:
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1.
  - out_* data are don't-care but driven from entry 0; the storage array is not reset.
- Storage and pointers:
  - DEPTH-entry register array of 97-bit packets {pre_direction, pre_pc, pc, instr}.
  - wr_ptr and rd_ptr are PTR_W+1 bits wide.
  - empty = (wr_ptr==rd_ptr).
  - full = index bits equal and wrap bits differ.
  - count = wr_ptr - rd_ptr, modulo 2^(PTR_W+1).
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = !full. It is combinational from state only and never depends on out_ready.
  - out_valid = !empty (non-bypass build).
  - out_* = entry[rd_ptr index], combinational read of the head.
- Latency: a packet pushed in cycle N is visible on out_* with out_valid=1 in cycle N+1.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When count=1, the popped head is the old entry and the new entry becomes head next cycle.
- Full: in_ready=0; in_valid is ignored; no entry is overwritten. A pop in the same cycle does not enable a push that cycle.
- Empty: out_valid=0; out_ready is ignored; rd_ptr does not move.
- Wrap-around: index bits roll from DEPTH-1 to 0 and the wrap bit toggles. Order is preserved across wrap.
- Flush:
  - Highest priority after rst: wr_ptr<=0, rd_ptr<=0, count becomes 0 next cycle.
  - A push or pop in the same cycle is discarded; no entry survives.
  - in_ready stays at its pre-flush value during the flush cycle; fetch must not rely on acceptance that cycle.
- rst asserted mid-stream: identical to flush plus all outputs at reset values next cycle.
- No state machine beyond pointer state. The queue is one of three occupancy states, EMPTY, PARTIAL or FULL, derived from the pointers.
- Packets are not inspected or modified; fields pass through bit-exact.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When empty and in_valid=1, out_valid=1 in the same cycle and out_* are driven directly from in_*.
  - If out_ready=1 that cycle, the packet is consumed without being written; pointers are unchanged.
  - If out_ready=0, the packet is written normally and becomes head.
  - in_ready is unchanged (still !full).
  - Latency becomes 0 cycles when empty.
  - flush in the same cycle suppresses out_valid.
- Not defined: no combinational in->out path; fixed 1-cycle minimum latency as described in Behaviour.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then release -> out_valid=0, in_ready=1, count=0.
  - Pulse out_ready=1 with nothing pushed -> nothing changes.
- Ordered fill and drain:
  - Push 8 packets (instr=0x00000013+i, pc=0x80000000+4i, pre_pc=pc+4, pre_direction=i[0]) with out_ready=0 -> count=8, in_ready=0.
  - 9th in_valid ignored.
  - Drain -> outputs match in order; count returns to 0.
- Wrap-around: repeat push 5 / pop 5 for three rounds -> all 15 packets out in order, no loss or duplication across the index wrap.
- Simultaneous push/pop:
  - count=3, in_valid=1, out_ready=1 for 4 cycles -> count stays 3.
  - Head sequence advances by one per cycle.
  - Full with out_ready=1 and in_valid=1 -> only the pop happens; count=7.
- Flush mid-stream:
  - count=5, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0.
  - Next push of pc=0x80000100 is the first packet out.
- Bypass (FETCH_QUEUE_BYPASS_EN defined):
  - Empty, in_valid=1, out_ready=1, in_pc=0x80000200 -> same cycle out_valid=1, out_pc=0x80000200; count stays 0.
  - Repeat with out_ready=0 -> count=1.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: in-order packet buffer between fetch and decode, cleared whole on redirect.
// Optional same-cycle bypass when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.

package fetch_queue_pkg;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic            pre_direction;
        logic [XLEN-1:0] pre_pc;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_pre_pc,
    input  logic             in_pre_direction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pre_pc,
    output logic             out_pre_direction,
    output logic [PTR_W:0]   count
);

    fetch_pkt_t         mem [DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [PTR_W-1:0]   wr_idx;
    logic [PTR_W-1:0]   rd_idx;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic               rd_en;
    fetch_pkt_t         in_pkt;
    fetch_pkt_t         head_pkt;
    fetch_pkt_t         out_pkt;

    assign in_pkt = '{pre_direction: in_pre_direction,
                      pre_pc:        in_pre_pc,
                      pc:            in_pc,
                      instr:         in_instr};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign wr_idx = wr_ptr[PTR_W-1:0];
    assign rd_idx = rd_ptr[PTR_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign count  = wr_ptr - rd_ptr;

    assign in_ready = ~full;
    assign head_pkt = mem[rd_idx];
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards the incoming packet straight to decode.
    logic bypass;
    assign bypass    = empty & in_valid & ~flush;
    assign out_valid = ~empty | bypass;
    assign out_pkt   = bypass ? in_pkt : head_pkt;
    assign wr_en     = push & ~(bypass & out_ready);
    assign rd_en     = pop & ~empty;
`else
    assign out_valid = ~empty;
    assign out_pkt   = head_pkt;
    assign wr_en     = push;
    assign rd_en     = pop;
`endif

    assign out_instr         = out_pkt.instr;
    assign out_pc            = out_pkt.pc;
    assign out_pre_pc        = out_pkt.pre_pc;
    assign out_pre_direction = out_pkt.pre_direction;

    // Pointer state; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Packet storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !flush && !rst) begin
            mem[wr_idx] <= in_pkt;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed steps then random traffic against a queue-based model.
// Bypass expectations follow FETCH_QUEUE_BYPASS_EN when defined.

module tb_fetch_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_pre_pc;
    logic        in_pre_direction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pre_pc;
    logic        out_pre_direction;
    logic [PTR_W:0] count;

    int checks = 0;
    int errors = 0;

    // Model: packets as {pre_direction, pre_pc, pc, instr}
    logic [96:0] q[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_pre_pc(in_pre_pc),
        .in_pre_direction(in_pre_direction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pre_pc(out_pre_pc),
        .out_pre_direction(out_pre_direction),
        .count(count)
    );

    function automatic logic [96:0] plan_pkt(input int i);
        logic [31:0] pc;
        logic [31:0] iv;
        iv = 32'(i);
        pc = 32'h8000_0000 + 32'(4 * i);
        return {iv[0], pc + 32'd4, pc, 32'h0000_0013 + iv};
    endfunction

    function automatic logic [96:0] rand_pkt();
        return {1'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [96:0] p, input logic ordy, input logic fl);
        in_valid         = v;
        in_pre_direction = p[96];
        in_pre_pc        = p[95:64];
        in_pc            = p[63:32];
        in_instr         = p[31:0];
        out_ready        = ordy;
        flush            = fl;
    endtask

    // Check outputs against the model for the current inputs, then advance one clock.
    task automatic cycle();
        logic        exp_ovalid;
        logic [96:0] exp_pkt;
        logic [96:0] cur;
        logic        bypass;
        int          sz;
        #1;
        sz      = q.size();
        cur     = {in_pre_direction, in_pre_pc, in_pc, in_instr};
        bypass  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass  = (sz == 0) && in_valid && !flush;
`endif
        exp_ovalid = (sz != 0) || bypass;
        exp_pkt    = bypass ? cur : ((sz != 0) ? q[0] : '0);
        check("in_ready", 64'(in_ready), 64'(sz != DEPTH));
        check("out_valid", 64'(out_valid), 64'(exp_ovalid));
        check("count", 64'(count), 64'(sz));
        if (exp_ovalid) begin
            check("out_instr", 64'(out_instr), 64'(exp_pkt[31:0]));
            check("out_pc", 64'(out_pc), 64'(exp_pkt[63:32]));
            check("out_pre_pc", 64'(out_pre_pc), 64'(exp_pkt[95:64]));
            check("out_pre_dir", 64'(out_pre_direction), 64'(exp_pkt[96]));
        end
        if (rst || flush) begin
            q.delete();
        end else if (bypass) begin
            if (!out_ready) q.push_back(cur);
        end else begin
            if (sz != 0 && out_ready) void'(q.pop_front());
            if (in_valid && sz != DEPTH) q.push_back(cur);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0);
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset then idle, with a stray out_ready pulse
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        idle();
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        idle();

        // Ordered fill, ignored 9th push, drain
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, plan_pkt(i), 1'b0, 1'b0);
            cycle();
        end
        check("full_count", 64'(count), 64'd8);
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, plan_pkt(8), 1'b0, 1'b0);
        cycle();
        check("first_out_pc", 64'(out_pc), 64'h8000_0000);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            cycle();
        end
        check("drained_count", 64'(count), 64'd0);
        idle();

        // Wrap-around: push 5 / pop 5, three rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, plan_pkt(16 + 5 * r + i), 1'b0, 1'b0);
                cycle();
            end
            for (int i = 0; i < 5; i++) begin
                drive(1'b0, '0, 1'b1, 1'b0);
                cycle();
            end
        end
        check("wrap_count", 64'(count), 64'd0);

        // Simultaneous push/pop at count=3, then at full
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, plan_pkt(40 + i), 1'b0, 1'b0);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, plan_pkt(43 + i), 1'b1, 1'b0);
            cycle();
        end
        check("pp_count", 64'(count), 64'd3);
        check("pp_head_pc", 64'(out_pc), 64'(32'h8000_0000 + 32'(4 * 44)));
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, plan_pkt(47 + i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, plan_pkt(52), 1'b1, 1'b0);
        cycle();
        check("full_pp_count", 64'(count), 64'd7);
        idle();

        // Flush mid-stream at count=5 with push and pop
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, plan_pkt(60 + i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, plan_pkt(65), 1'b1, 1'b1);
        cycle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        drive(1'b1, plan_pkt(64), 1'b0, 1'b0);
        cycle();
        check("post_flush_pc", 64'(out_pc), 64'h8000_0100);
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();

`ifdef FETCH_QUEUE_BYPASS_EN
        // Bypass when empty: consumed same cycle, or written when not consumed
        drive(1'b1, plan_pkt(128), 1'b1, 1'b0);
        #1;
        check("byp_out_valid", 64'(out_valid), 64'd1);
        check("byp_out_pc", 64'(out_pc), 64'h8000_0200);
        cycle();
        check("byp_count0", 64'(count), 64'd0);
        drive(1'b1, plan_pkt(128), 1'b0, 1'b0);
        cycle();
        check("byp_count1", 64'(count), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
`endif

        // Random traffic including flushes and mid-stream reset
        for (int n = 0; n < 2000; n++) begin
            drive(1'($urandom_range(0, 9) < 6), rand_pkt(),
                  1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 99) < 3));
            rst = 1'($urandom_range(0, 99) < 1);
            cycle();
        end
        rst = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
